lane_lock_sequencer: RTL and testbench



---
 rtl/lane_lock_sequencer.sv | 173 +++++++++++++++++
 tb/tb_lane_lock_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_lock_sequencer.sv
// Supervises LANES decoder lanes: per-lane hold/wait/locked sequencing with retry on lock timeout.
// Optional per-lane loss-of-lock statistics are built when LANE_LOCK_STATS_EN is defined.
module lane_lock_sequencer #(
  parameter int LANES        = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic             USER_CLK,
  input  logic             SYSTEM_RESET,
  input  logic             ENABLE,
  input  logic [LANES-1:0] NOT_LOCKED,
  input  logic [LANES-1:0] RESYNC_REQ,
  output logic [LANES-1:0] PASSTHROUGH,
  output logic [LANES-1:0] LANE_LOCKED,
  output logic             ALL_LOCKED,
  output logic [LANES-1:0] RETRY_EVENT,
  input  logic [2:0]       STAT_SEL,
  output logic [7:0]       STAT_COUNT
);

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    WAIT_LOCK  = 2'd1,
    LOCKED     = 2'd2
  } lane_state_e;

  logic all_locked_q;

`ifdef LANE_LOCK_STATS_EN
  logic [LANES-1:0][7:0] loss_w;
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] tmo_q, tmo_d;
    logic        retry_q, retry_d;
    logic        pass_o, locked_o;

    always_ff @(posedge USER_CLK) begin
      if (SYSTEM_RESET) begin
        state_q <= RESET_HOLD;
        hold_q  <= '0;
        tmo_q   <= '0;
        retry_q <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        tmo_q   <= tmo_d;
        retry_q <= retry_d;
      end
    end

    // Disable and forced resync outrank every other transition, so they
    // never produce a retry pulse or a loss count.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      tmo_d   = tmo_q;
      retry_d = 1'b0;
      if (!ENABLE || RESYNC_REQ[gi]) begin
        state_d = RESET_HOLD;
        hold_d  = '0;
        tmo_d   = '0;
      end else begin
        case (state_q)
          RESET_HOLD: begin
            if (hold_q == HOLD_LAST) begin
              state_d = WAIT_LOCK;
              hold_d  = '0;
              tmo_d   = '0;
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end
          WAIT_LOCK: begin
            if (!NOT_LOCKED[gi]) begin
              state_d = LOCKED;
            end else if (tmo_q == TMO_LAST) begin
              state_d = RESET_HOLD;
              hold_d  = '0;
              retry_d = 1'b1;
            end else begin
              tmo_d = tmo_q + 16'd1;
            end
          end
          LOCKED: begin
            if (NOT_LOCKED[gi]) begin
              state_d = WAIT_LOCK;
              tmo_d   = '0;
            end
          end
          default: begin
            state_d = RESET_HOLD;
            hold_d  = '0;
            tmo_d   = '0;
          end
        endcase
      end
    end

    always_comb begin
      pass_o   = 1'b0;
      locked_o = 1'b0;
      case (state_q)
        RESET_HOLD: pass_o = 1'b1;
        LOCKED:     locked_o = 1'b1;
        default:    ;
      endcase
    end

    assign PASSTHROUGH[gi] = pass_o;
    assign LANE_LOCKED[gi] = locked_o;
    assign RETRY_EVENT[gi] = retry_q;

`ifdef LANE_LOCK_STATS_EN
    logic [7:0] loss_q;

    // The only LOCKED -> WAIT_LOCK transition is a loss of lock.
    always_ff @(posedge USER_CLK) begin
      if (SYSTEM_RESET) begin
        loss_q <= '0;
      end else if (state_q == LOCKED && state_d == WAIT_LOCK && loss_q != 8'hFF) begin
        loss_q <= loss_q + 8'd1;
      end
    end

    assign loss_w[gi] = loss_q;
`endif
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= &LANE_LOCKED;
    end
  end

  assign ALL_LOCKED = all_locked_q;

`ifdef LANE_LOCK_STATS_EN
  logic [7:0] stat_q, stat_d;

  // Lane indices at or beyond LANES read as zero.
  always_comb begin
    stat_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (STAT_SEL == 3'(i)) begin
        stat_d = loss_w[i];
      end
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign STAT_COUNT = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^STAT_SEL;
  assign STAT_COUNT      = 8'd0;
`endif

endmodule

// File: tb/tb_lane_lock_sequencer.sv
// Bench for lane_lock_sequencer: startup vector table, directed corner sequences,
// then randomized traffic checked against a cycle-age reference model.
module tb_lane_lock_sequencer;

  localparam int LANES = 4;
  localparam int HOLD  = 8;
  localparam int TMO   = 16;
`ifdef LANE_LOCK_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic             USER_CLK = 1'b0;
  logic             SYSTEM_RESET;
  logic             ENABLE;
  logic [LANES-1:0] NOT_LOCKED;
  logic [LANES-1:0] RESYNC_REQ;
  logic [LANES-1:0] PASSTHROUGH;
  logic [LANES-1:0] LANE_LOCKED;
  logic             ALL_LOCKED;
  logic [LANES-1:0] RETRY_EVENT;
  logic [2:0]       STAT_SEL;
  logic [7:0]       STAT_COUNT;

  lane_lock_sequencer #(
    .LANES(LANES), .HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TMO)
  ) dut (
    .USER_CLK(USER_CLK), .SYSTEM_RESET(SYSTEM_RESET), .ENABLE(ENABLE),
    .NOT_LOCKED(NOT_LOCKED), .RESYNC_REQ(RESYNC_REQ), .PASSTHROUGH(PASSTHROUGH),
    .LANE_LOCKED(LANE_LOCKED), .ALL_LOCKED(ALL_LOCKED), .RETRY_EVENT(RETRY_EVENT),
    .STAT_SEL(STAT_SEL), .STAT_COUNT(STAT_COUNT)
  );

  always #5 USER_CLK = ~USER_CLK;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endfunction

  // Reference model: each lane is a mode (0 hold, 1 waiting, 2 locked) plus the
  // number of cycles it has already completed in that mode.
  int         m_mode [LANES];
  int         m_age  [LANES];
  int         m_loss [LANES];
  logic [3:0] m_retry;
  logic       m_all;
  logic [7:0] m_stat;

  function automatic void model_step();
    logic all_now;
    int   sel_i;
    int   stat_now;
    all_now  = 1'b1;
    stat_now = 0;
    for (int i = 0; i < LANES; i++) if (m_mode[i] != 2) all_now = 1'b0;
    sel_i = int'(STAT_SEL);
    if (sel_i < LANES && STATS_ON) stat_now = m_loss[sel_i];
    m_retry = '0;
    if (SYSTEM_RESET) begin
      for (int i = 0; i < LANES; i++) begin
        m_mode[i] = 0; m_age[i] = 0; m_loss[i] = 0;
      end
      m_all  = 1'b0;
      m_stat = 8'd0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (!ENABLE || RESYNC_REQ[i]) begin
          m_mode[i] = 0; m_age[i] = 0;
        end else if (m_mode[i] == 0) begin
          m_age[i]++;
          if (m_age[i] == HOLD) begin m_mode[i] = 1; m_age[i] = 0; end
        end else if (m_mode[i] == 1) begin
          if (!NOT_LOCKED[i]) begin
            m_mode[i] = 2; m_age[i] = 0;
          end else begin
            m_age[i]++;
            if (m_age[i] == TMO) begin m_mode[i] = 0; m_age[i] = 0; m_retry[i] = 1'b1; end
          end
        end else if (NOT_LOCKED[i]) begin
          m_mode[i] = 1; m_age[i] = 0;
          if (m_loss[i] < 255) m_loss[i]++;
        end
      end
      m_all  = all_now;
      m_stat = 8'(stat_now);
    end
  endfunction

  task automatic tick();
    logic [3:0] e_pt, e_lk;
    @(posedge USER_CLK);
    model_step();
    #2;
    for (int i = 0; i < LANES; i++) begin
      e_pt[i] = (m_mode[i] == 0);
      e_lk[i] = (m_mode[i] == 2);
    end
    check("passthrough", PASSTHROUGH, e_pt);
    check("lane_locked", LANE_LOCKED, e_lk);
    check("all_locked", ALL_LOCKED, m_all);
    check("retry_event", RETRY_EVENT, m_retry);
    check("stat_count", STAT_COUNT, m_stat);
  endtask

  task automatic wait_all_locked(string name);
    int k;
    k = 0;
    while (ALL_LOCKED !== 1'b1 && k < 60) begin tick(); k++; end
    check(name, ALL_LOCKED, 1);
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] nl;
    logic [3:0] rs;
    logic [3:0] pt;
    logic [3:0] lk;
    logic       all;
    logic [3:0] rt;
  } vec_t;

  vec_t       vt [12];
  logic [3:0] nl_r;
  logic [3:0] rs_v;
  int         cnt;
  int         k;

  initial begin
    SYSTEM_RESET = 1'b1; ENABLE = 1'b1; NOT_LOCKED = '0; RESYNC_REQ = '0; STAT_SEL = '0;
    for (int i = 0; i < LANES; i++) begin m_mode[i] = 0; m_age[i] = 0; m_loss[i] = 0; end
    m_retry = '0; m_all = 1'b0; m_stat = '0;

    // Startup after reset: 8 hold cycles, one wait cycle, locked, then ALL_LOCKED.
    vt[0] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0};
    for (int v = 1; v < 8; v++) vt[v] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0};
    vt[8]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    vt[9]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 4'h0};
    vt[10] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 4'h0};
    vt[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 4'h0};
    for (int v = 0; v < 12; v++) begin
      SYSTEM_RESET = vt[v].rst; ENABLE = vt[v].en; NOT_LOCKED = vt[v].nl; RESYNC_REQ = vt[v].rs;
      tick();
      check("tbl_pt", PASSTHROUGH, vt[v].pt);
      check("tbl_lk", LANE_LOCKED, vt[v].lk);
      check("tbl_all", ALL_LOCKED, vt[v].all);
      check("tbl_retry", RETRY_EVENT, vt[v].rt);
    end

    // Lane 2 never locks: 16 wait cycles, retry pulse, 8 hold cycles, twice.
    NOT_LOCKED = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      cnt = (r == 0) ? 0 : 1; k = 0;
      while (k < 40) begin
        tick(); k++;
        if (PASSTHROUGH[2] === 1'b1) break;
        cnt++;
      end
      check("a_wait_len", cnt, 16);
      check("a_retry", RETRY_EVENT, 4'b0100);
      check("a_others_locked", LANE_LOCKED & 4'b1011, 4'b1011);
      check("a_all_low", ALL_LOCKED, 0);
      cnt = 1; k = 0;
      while (k < 20) begin
        tick(); k++;
        if (PASSTHROUGH[2] !== 1'b1) break;
        cnt++;
      end
      check("a_hold_len", cnt, 8);
    end
    NOT_LOCKED = 4'b0000;
    wait_all_locked("a_relock");

    // Lane 1 drops lock for 3 cycles, then relocks; loss count readout.
    NOT_LOCKED = 4'b0010;
    repeat (3) tick();
    check("b_lane1_down", LANE_LOCKED[1], 0);
    check("b_all_drop", ALL_LOCKED, 0);
    NOT_LOCKED = 4'b0000;
    wait_all_locked("b_relock");
    STAT_SEL = 3'd1; tick(); tick();
    check("b_stat_lane1", STAT_COUNT, STATS_ON ? 32'd1 : 32'd0);
    STAT_SEL = 3'd5; tick();
    check("b_stat_sel5", STAT_COUNT, 0);
    STAT_SEL = 3'd2; tick();
    check("b_stat_lane2", STAT_COUNT, STATS_ON ? 32'd1 : 32'd0);

    // Resync coincides with lane 0 timeout, then again at hold count 5.
    NOT_LOCKED = 4'b0001;
    tick();
    repeat (15) tick();
    check("c_still_waiting", PASSTHROUGH[0] | LANE_LOCKED[0], 0);
    RESYNC_REQ = 4'b0001; tick();
    check("c_no_retry", RETRY_EVENT, 0);
    check("c_in_hold", PASSTHROUGH[0], 1);
    RESYNC_REQ = 4'b0000; cnt = 1;
    repeat (5) begin tick(); if (PASSTHROUGH[0] === 1'b1) cnt++; end
    RESYNC_REQ = 4'b0001; tick(); if (PASSTHROUGH[0] === 1'b1) cnt++;
    RESYNC_REQ = 4'b0000; k = 0;
    while (PASSTHROUGH[0] === 1'b1 && k < 30) begin
      tick(); k++;
      if (PASSTHROUGH[0] === 1'b1) cnt++;
    end
    check("c_hold_total", cnt, 14);
    NOT_LOCKED = 4'b0000;
    wait_all_locked("c_relock");

    // 300 losses on lane 3 saturate its counter; reset mid-wait clears everything.
    for (int n = 0; n < 300; n++) begin
      NOT_LOCKED = 4'b1000; tick();
      NOT_LOCKED = 4'b0000; tick();
    end
    STAT_SEL = 3'd3; tick(); tick();
    check("d_stat_sat", STAT_COUNT, STATS_ON ? 32'd255 : 32'd0);
    NOT_LOCKED = 4'b1000; tick(); tick();
    check("d_lane3_waiting", PASSTHROUGH[3] | LANE_LOCKED[3], 0);
    SYSTEM_RESET = 1'b1; tick();
    check("d_rst_pt", PASSTHROUGH, 4'hF);
    check("d_rst_stat", STAT_COUNT, 0);
    check("d_rst_lk", LANE_LOCKED, 0);
    check("d_rst_all", ALL_LOCKED, 0);
    SYSTEM_RESET = 1'b0; NOT_LOCKED = 4'b0000;

    // Randomized traffic against the model.
    nl_r = '0;
    for (int c = 0; c < 2000; c++) begin
      SYSTEM_RESET = ($urandom_range(0, 199) == 0);
      ENABLE       = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 14) == 0) nl_r[i] = ~nl_r[i];
        rs_v[i] = ($urandom_range(0, 79) == 0);
      end
      NOT_LOCKED = nl_r;
      RESYNC_REQ = rs_v;
      STAT_SEL   = 3'($urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
